// File: rtl/rom_table_loader.sv
// rom_table_loader: packs a little-endian host byte stream into DWIDTH-bit
// entries and writes them into a table RAM, starting at a commanded base
// address for a commanded number of entries. Completion and framing errors
// are reported as single-cycle pulses (done / err).
//
// Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready.
// A byte transfers on a rising edge where s_valid && s_ready. Ready never
// depends on valid; both readies are decoded from the state register only.
module rom_table_loader #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    localparam int NBYTES = (DWIDTH + 7) / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_base,
    input  logic [AWIDTH:0]   cmd_count,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AWIDTH:0]   written
);

    localparam int CW = AWIDTH + 1;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic [AWIDTH:0]   written_q, written_d;
    logic [IDXW-1:0]   byte_idx_q, byte_idx_d;
    logic [DWIDTH-1:0] packer_q, packer_d;
    logic              err_pend_q, err_pend_d;
    logic              mem_we_q, mem_we_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [DWIDTH-1:0] entry;
    logic              accept;
    logic              last_lane;
    logic              last_entry;

    // State register and datapath flops; reset aborts any load in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            written_q   <= '0;
            byte_idx_q  <= '0;
            packer_q    <= '0;
            err_pend_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            written_q   <= written_d;
            byte_idx_q  <= byte_idx_d;
            packer_q    <= packer_d;
            err_pend_q  <= err_pend_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state logic: command latch, byte packing, entry writes and framing checks.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        written_d   = written_q;
        byte_idx_d  = byte_idx_q;
        packer_d    = packer_q;
        err_pend_d  = err_pend_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // The packer is cleared at every entry start, so OR-ing the new lane in is enough.
        // Pad bits of the top lane fall off the DWIDTH-wide shift.
        entry = packer_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_idx_q == IDXW'(i)) begin
                entry = packer_q | (DWIDTH'(s_data) << (i * 8));
            end
        end

        accept     = s_valid && (state_q == S_LOAD || state_q == S_DRAIN);
        last_lane  = (byte_idx_q == IDXW'(NBYTES - 1));
        last_entry = ((written_q + CW'(1)) == count_q);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_base;
                    count_d    = (cmd_count > DEPTH) ? DEPTH : cmd_count;
                    written_d  = '0;
                    byte_idx_d = '0;
                    packer_d   = '0;
                    err_pend_d = 1'b0;
                    state_d    = (cmd_count == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    packer_d   = entry;
                    byte_idx_d = byte_idx_q + IDXW'(1);
                    if (last_lane) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = entry;
                        addr_d      = addr_q + AWIDTH'(1);
                        written_d   = written_q + CW'(1);
                        byte_idx_d  = '0;
                        packer_d    = '0;
                        if (last_entry) begin
                            state_d    = s_last ? S_FIN : S_DRAIN;
                            err_pend_d = !s_last;
                        end else if (s_last) begin
                            state_d    = S_FIN;
                            err_pend_d = 1'b1;
                        end
                    end else if (s_last) begin
                        // Frame ended mid-entry: drop the partial entry.
                        byte_idx_d = '0;
                        packer_d   = '0;
                        state_d    = S_FIN;
                        err_pend_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && s_last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d    = S_IDLE;
                err_pend_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign s_ready   = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign err       = (state_q == S_FIN) && err_pend_q;
    assign written   = written_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rom_table_loader.sv
// Bench for rom_table_loader: three instances (DWIDTH 8, 12, 16) share clock,
// reset and stream data; one instance is selected at a time. Expected table
// writes are queued when the completing byte is driven and popped when mem_we
// is seen.
module tb_rom_table_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cmd_base;
    logic [8:0]  cmd_count;
    logic [7:0]  s_data;
    logic        s_last;
    logic        cmd_valid_v [3];
    logic        s_valid_v   [3];
    logic        cmd_ready_a [3];
    logic        s_ready_a   [3];
    logic        mem_we_a    [3];
    logic        busy_a      [3];
    logic        done_a      [3];
    logic        err_a       [3];
    logic [7:0]  mem_addr_a  [3];
    logic [8:0]  written_a   [3];
    logic [7:0]  wd8;
    logic [11:0] wd12;
    logic [15:0] wd16;

    int sel;
    int tests;
    int fails;
    logic [23:0] exp_q[$];

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed hang, required completion");
        $fatal(1, "watchdog");
    end

    rom_table_loader #(.DWIDTH(8), .AWIDTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_v[0]), .cmd_ready(cmd_ready_a[0]),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .s_data(s_data), .s_valid(s_valid_v[0]), .s_last(s_last), .s_ready(s_ready_a[0]),
        .mem_we(mem_we_a[0]), .mem_addr(mem_addr_a[0]), .mem_wdata(wd8),
        .busy(busy_a[0]), .done(done_a[0]), .err(err_a[0]), .written(written_a[0])
    );

    rom_table_loader #(.DWIDTH(12), .AWIDTH(8)) u_d12 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_v[1]), .cmd_ready(cmd_ready_a[1]),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .s_data(s_data), .s_valid(s_valid_v[1]), .s_last(s_last), .s_ready(s_ready_a[1]),
        .mem_we(mem_we_a[1]), .mem_addr(mem_addr_a[1]), .mem_wdata(wd12),
        .busy(busy_a[1]), .done(done_a[1]), .err(err_a[1]), .written(written_a[1])
    );

    rom_table_loader #(.DWIDTH(16), .AWIDTH(8)) u_d16 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_v[2]), .cmd_ready(cmd_ready_a[2]),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .s_data(s_data), .s_valid(s_valid_v[2]), .s_last(s_last), .s_ready(s_ready_a[2]),
        .mem_we(mem_we_a[2]), .mem_addr(mem_addr_a[2]), .mem_wdata(wd16),
        .busy(busy_a[2]), .done(done_a[2]), .err(err_a[2]), .written(written_a[2])
    );

    function automatic logic [15:0] wdata(input int d);
        case (d)
            0:       return {8'h00, wd8};
            1:       return {4'h0, wd12};
            default: return wd16;
        endcase
    endfunction

    // Scoreboard: every mem_we must match the oldest queued {addr, data}.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (mem_we_a[d] === 1'b1) begin
                tests++;
                if (d != sel || exp_q.size() == 0) begin
                    fails++;
                    $error("FAIL unexpected_write: dut=%0d observed addr=%h data=%h, required no write",
                           d, mem_addr_a[d], wdata(d));
                end else begin
                    logic [23:0] got;
                    logic [23:0] want;
                    got  = {mem_addr_a[d], wdata(d)};
                    want = exp_q.pop_front();
                    assert (got === want) else begin
                        fails++;
                        $error("FAIL write: dut=%0d observed %h required %h", d, got, want);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Driver: issue one command on instance d; returns at the negedge after the accepting edge.
    task automatic send_cmd(input int d, input logic [7:0] base, input logic [8:0] cnt);
        int n = 0;
        cmd_base       = base;
        cmd_count      = cnt;
        cmd_valid_v[d] = 1'b1;
        while (cmd_ready_a[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid_v[d] = 1'b0;
    endtask

    // Driver: send one byte; if it completes an entry, queue the expected write
    // and check that mem_we appears exactly one cycle after the accepting edge.
    task automatic send_byte(input int d, input logic [7:0] b, input logic last,
                             input logic we_exp, input logic [7:0] addr, input logic [15:0] data);
        int n = 0;
        s_data       = b;
        s_last       = last;
        s_valid_v[d] = 1'b1;
        while (s_ready_a[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", 32'(n < 20), 32'd1);
        if (we_exp) exp_q.push_back({addr, data});
        @(posedge clk);
        @(negedge clk);
        chk("we_latency", 32'(mem_we_a[d]), 32'(we_exp));
        s_valid_v[d] = 1'b0;
        s_last       = 1'b0;
    endtask

    task automatic chk_done(input int d, input logic e, input logic [8:0] w);
        chk("done_pulse", 32'(done_a[d]), 32'd1);
        chk("err_pulse", 32'(err_a[d]), 32'(e));
        chk("written", 32'(written_a[d]), 32'(w));
        chk("fin_s_ready", 32'(s_ready_a[d]), 32'd0);
        chk("fin_cmd_ready", 32'(cmd_ready_a[d]), 32'd0);
        @(negedge clk);
        chk("done_cleared", 32'(done_a[d]), 32'd0);
        chk("err_cleared", 32'(err_a[d]), 32'd0);
        chk("idle_cmd_ready", 32'(cmd_ready_a[d]), 32'd1);
        chk("written_hold", 32'(written_a[d]), 32'(w));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        sel       = 0;
        rst_n     = 1'b0;
        cmd_base  = '0;
        cmd_count = '0;
        s_data    = '0;
        s_last    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            cmd_valid_v[d] = 1'b0;
            s_valid_v[d]   = 1'b0;
        end

        // Reset values.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_cmd_ready", 32'(cmd_ready_a[d]), 32'd1);
            chk("rst_busy", 32'(busy_a[d]), 32'd0);
            chk("rst_s_ready", 32'(s_ready_a[d]), 32'd0);
            chk("rst_done", 32'(done_a[d]), 32'd0);
            chk("rst_mem_we", 32'(mem_we_a[d]), 32'd0);
            chk("rst_written", 32'(written_a[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // DWIDTH=8: three single-byte entries.
        sel = 0;
        send_cmd(0, 8'h10, 9'd3);
        chk("load_s_ready", 32'(s_ready_a[0]), 32'd1);
        chk("load_busy", 32'(busy_a[0]), 32'd1);
        send_byte(0, 8'hA1, 1'b0, 1'b1, 8'h10, 16'h00A1);
        send_byte(0, 8'hB2, 1'b0, 1'b1, 8'h11, 16'h00B2);
        send_byte(0, 8'hC3, 1'b1, 1'b1, 8'h12, 16'h00C3);
        chk_done(0, 1'b0, 9'd3);

        // DWIDTH=12: two bytes per entry, pad nibble dropped, address wraps.
        sel = 1;
        send_cmd(1, 8'hFE, 9'd3);
        send_byte(1, 8'h34, 1'b0, 1'b0, 8'h00, 16'h0000);
        send_byte(1, 8'hF2, 1'b0, 1'b1, 8'hFE, 16'h0234);
        send_byte(1, 8'h56, 1'b0, 1'b0, 8'h00, 16'h0000);
        send_byte(1, 8'hF1, 1'b0, 1'b1, 8'hFF, 16'h0156);
        send_byte(1, 8'h78, 1'b0, 1'b0, 8'h00, 16'h0000);
        send_byte(1, 8'hF0, 1'b1, 1'b1, 8'h00, 16'h0078);
        chk_done(1, 1'b0, 9'd3);

        // DWIDTH=16: early s_last drops the partial second entry.
        sel = 2;
        send_cmd(2, 8'h20, 9'd2);
        send_byte(2, 8'h11, 1'b0, 1'b0, 8'h00, 16'h0000);
        send_byte(2, 8'h22, 1'b0, 1'b1, 8'h20, 16'h2211);
        send_byte(2, 8'h33, 1'b1, 1'b0, 8'h00, 16'h0000);
        chk_done(2, 1'b1, 9'd1);

        // DWIDTH=8: frame longer than the command, extra bytes drained.
        sel = 0;
        send_cmd(0, 8'h30, 9'd2);
        send_byte(0, 8'h01, 1'b0, 1'b1, 8'h30, 16'h0001);
        send_byte(0, 8'h02, 1'b0, 1'b1, 8'h31, 16'h0002);
        chk("drain_done", 32'(done_a[0]), 32'd0);
        chk("drain_s_ready", 32'(s_ready_a[0]), 32'd1);
        send_byte(0, 8'h03, 1'b0, 1'b0, 8'h00, 16'h0000);
        send_byte(0, 8'h04, 1'b1, 1'b0, 8'h00, 16'h0000);
        chk_done(0, 1'b1, 9'd2);

        // count=0: done right after the command, stream ignored.
        s_valid_v[0] = 1'b1;
        s_data       = 8'hEE;
        send_cmd(0, 8'h40, 9'd0);
        chk("zero_s_ready", 32'(s_ready_a[0]), 32'd0);
        chk_done(0, 1'b0, 9'd0);
        s_valid_v[0] = 1'b0;

        // Oversized count clamps to the full depth: 256 entries, wrap, no error.
        send_cmd(0, 8'h80, 9'h1FF);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send_byte(0, b, 1'(i == 255), 1'b1, 8'(8'h80 + i), {8'h00, b});
        end
        chk_done(0, 1'b0, 9'h100);

        // Reset mid-load: asynchronous clear, no further writes, clean restart.
        send_cmd(0, 8'h60, 9'd3);
        send_byte(0, 8'h5A, 1'b0, 1'b1, 8'h60, 16'h005A);
        s_valid_v[0] = 1'b1;
        s_data       = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_cmd_ready", 32'(cmd_ready_a[0]), 32'd1);
        chk("amid_busy", 32'(busy_a[0]), 32'd0);
        chk("amid_s_ready", 32'(s_ready_a[0]), 32'd0);
        chk("amid_mem_we", 32'(mem_we_a[0]), 32'd0);
        chk("amid_mem_addr", 32'(mem_addr_a[0]), 32'd0);
        chk("amid_written", 32'(written_a[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n        = 1'b1;
        s_valid_v[0] = 1'b0;
        @(negedge clk);
        send_cmd(0, 8'h70, 9'd1);
        send_byte(0, 8'hC4, 1'b1, 1'b1, 8'h70, 16'h00C4);
        chk_done(0, 1'b0, 9'd1);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
